test_run_ctrl: RTL and testbench
================================

Name: test_run_ctrl

Overview:
Self-checking run controller for processor-level benches; it replaces manual waveform and $monitor inspection. It owns the core's reset, streams in an expected register-writeback trace (FIFO, parametrised depth and width), and compares every retired writeback in order. It detects program end by a halt instruction fetch, enforces a cycle timeout, and reports pass or fail with a fail code and captured mismatch data. It sits beside control_top in the bench top, probing instr_reg and the regfile write port.

Parameters:
XLEN, 64, register/data width
DEPTH, 16, expected-trace FIFO entries (power of 2)
RST_CYCLES, 4, cycles core_reset is held after start
TIMEOUT, 100000, max RUN cycles before failing
HALT_INSTR, 32'h0000006F, instruction word marking program end (jal x0,0)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin a run (IDLE or terminal state)
exp_valid  in  1  expected-entry push request
exp_addr  in  5  expected destination register
exp_data  in  XLEN  expected written value
exp_ready  out  1  push accepted when exp_valid && exp_ready
ir_load  in  1  instruction register load strobe
ir_data  in  32  instruction being loaded
wb_en  in  1  regfile write enable
wb_addr  in  5  regfile write address
wb_data  in  XLEN  regfile write data
core_reset  out  1  reset driven to control_top
done  out  1  run finished (sticky)
pass  out  1  valid when done
fail_code  out  3  0 NONE, 1 MISMATCH, 2 EXTRA, 3 MISSING, 4 TIMEOUT
fail_addr  out  5  wb_addr at failure
fail_data  out  XLEN  actual wb_data at failure
fail_exp  out  XLEN  expected data at failure (0 for EXTRA)
cycle_count  out  32  RUN cycles elapsed

Behaviour:
- Reset: state IDLE, core_reset=1, FIFO empty, done=0, pass=0, fail_code=0, fail_*=0, cycle_count=0. Reset mid-run aborts; outputs reach reset values in the following cycle.
- States: IDLE, HOLD, RUN, DONE. All outputs are registered.
- IDLE: core_reset=1. start -> HOLD; the hold counter loads RST_CYCLES.
- HOLD: core_reset=1 for exactly RST_CYCLES cycles, then RUN. core_reset falls on the first RUN cycle.
- RUN: core_reset=0. cycle_count increments every cycle.
- FIFO push: exp_ready = !full, computed from the registered count, in IDLE, HOLD and RUN. exp_ready=0 in DONE. A pop in the same cycle does not free space for that cycle's push.
- Writebacks with wb_addr==0 are ignored.
- Qualified writeback (wb_en, addr≠0) in RUN, compared against the registered FIFO head:
  - FIFO empty -> fail EXTRA. A push in the same cycle is not visible.
  - addr or data differ -> fail MISMATCH; capture fail_addr, fail_data, fail_exp.
  - match -> pop.
- Halt: ir_load && ir_data==HALT_INSTR in RUN -> DONE.
  - A writeback in the same cycle is evaluated first; its failure takes precedence.
  - pass=1 if the FIFO is empty after that cycle's pop; otherwise fail MISSING.
- Timeout: cycle_count reaching TIMEOUT with no halt -> fail TIMEOUT. cycle_count freezes at TIMEOUT.
- Any failure: next state DONE, done=1, pass=0. The first failure wins.
- DONE: core_reset=1 to freeze the core; all outputs hold.
- start in DONE: flush FIFO, clear done/pass/fail_*/cycle_count, go to HOLD.
- start outside IDLE/DONE is ignored.

Decomposition:
- Package test_pkg holds:
  - fail_code_t enum {FAIL_NONE, FAIL_MISMATCH, FAIL_EXTRA, FAIL_MISSING, FAIL_TIMEOUT}
  - run_state_t enum
  - HALT_INSTR default constant
  - packed struct exp_entry_t {addr[4:0], data[XLEN-1:0]}
- One sub-module: sync_fifo (parametrised WIDTH/DEPTH, flush, full/empty/count, registered head). The FSM, counters and capture logic live in test_run_ctrl.

Test Plan:
1. Happy path: push (1,0xA0),(2,2),(3,5); start; writebacks x1=0xA0, x0=7, x2=2, x3=5; fetch 0x0000006F -> done=1, pass=1, fail_code=0. core_reset is high for exactly 4 cycles after start.
2. Mismatch: expect (2,2), writeback x2=3 -> fail_code=1, fail_addr=2, fail_data=3, fail_exp=2, done next cycle, core_reset=1.
3. Extra and missing:
   - Empty FIFO, writeback x5=1 -> fail_code=2.
   - Rerun via start with (4,9) pushed and halt fetched -> fail_code=3.
4. Simultaneous events: last matching writeback in the same cycle as halt -> pass=1. Mismatching writeback with halt -> fail_code=1, not 3.
5. Timeout with TIMEOUT=50 and no halt -> fail_code=4 and cycle_count=50 at done.
6. FIFO full and reset:
   - DEPTH=16 pushes -> exp_ready=0; push+pop in the same cycle leaves exp_ready=0 that cycle.
   - reset asserted in RUN -> next cycle state IDLE, core_reset=1, all outputs at reset values.

Source files
------------

// File: rtl/test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_pkg
// Description : Shared types and constants for the test run controller:
//               failure codes, run-state encoding, the default halt
//               instruction word and the expected-trace entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package test_pkg;

  localparam int          DEF_XLEN       = 64;
  // jal x0,0 : a tight self-loop that programs use to signal completion
  localparam logic [31:0] HALT_INSTR_DEF = 32'h0000006F;

  typedef enum logic [2:0] {
    FAIL_NONE     = 3'd0,
    FAIL_MISMATCH = 3'd1,
    FAIL_EXTRA    = 3'd2,
    FAIL_MISSING  = 3'd3,
    FAIL_TIMEOUT  = 3'd4
  } fail_code_t;

  typedef enum logic [1:0] {
    RUN_IDLE = 2'd0,
    RUN_HOLD = 2'd1,
    RUN_RUN  = 2'd2,
    RUN_DONE = 2'd3
  } run_state_t;

  // Expected writeback at the default data width; the controller stores
  // entries in its FIFO with this same {addr, data} bit layout.
  typedef struct packed {
    logic [4:0]          addr;
    logic [DEF_XLEN-1:0] data;
  } exp_entry_t;

endpackage
`default_nettype wire

// File: rtl/test_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : test_run_ctrl_if
// Description : Bundle of the run controller's handshake and probe signals.
//               master : bench side (drives start, expected trace, probes)
//               slave  : controller side (drives reset, status, capture)
//   start/exp_valid/exp_addr/exp_data -> run control and trace push
//   exp_ready                          <- trace push accept
//   ir_load/ir_data, wb_en/wb_addr/wb_data -> probes into the core
//   core_reset, done, pass, fail_code, fail_addr, fail_data, fail_exp,
//   cycle_count                        <- run status
// Revision    : 1.0 - initial release
// ============================================================================
interface test_run_ctrl_if #(
  parameter int XLEN = 64
);

  logic            start;
  logic            exp_valid;
  logic [4:0]      exp_addr;
  logic [XLEN-1:0] exp_data;
  logic            exp_ready;
  logic            ir_load;
  logic [31:0]     ir_data;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            core_reset;
  logic            done;
  logic            pass;
  logic [2:0]      fail_code;
  logic [4:0]      fail_addr;
  logic [XLEN-1:0] fail_data;
  logic [XLEN-1:0] fail_exp;
  logic [31:0]     cycle_count;

  modport master (
    output start, exp_valid, exp_addr, exp_data, ir_load, ir_data,
           wb_en, wb_addr, wb_data,
    input  exp_ready, core_reset, done, pass, fail_code, fail_addr,
           fail_data, fail_exp, cycle_count
  );

  modport slave (
    input  start, exp_valid, exp_addr, exp_data, ir_load, ir_data,
           wb_en, wb_addr, wb_data,
    output exp_ready, core_reset, done, pass, fail_code, fail_addr,
           fail_data, fail_exp, cycle_count
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with flush. The head entry is read
//               straight from storage registers, so it is valid whenever
//               the FIFO is not empty and carries no input-to-output path.
//   clk, reset      : clock, synchronous active-high reset
//   flush           : empty the FIFO (overrides push/pop)
//   push, push_data : write request (ignored when full)
//   pop             : discard head (ignored when empty)
//   head            : oldest entry
//   full/empty/count: occupancy from the registered count
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 16   // power of two, >= 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int               PW       = $clog2(DEPTH);
  localparam int               CNTW     = PW + 1;
  localparam logic [CNTW-1:0]  FULL_CNT = CNTW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read below the valid count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/test_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : test_run_ctrl
// Description : Self-checking run controller. Holds the core in reset,
//               releases it for a run, compares every retired register
//               writeback against a streamed expected trace, stops on a
//               halt fetch or a cycle timeout and reports pass/fail.
//   clk, reset : clock, synchronous active-high reset
//   bus.slave  : start, expected-trace push (exp_*), instruction and
//                writeback probes (ir_*, wb_*), core_reset, done, pass,
//                fail_code/addr/data/exp, cycle_count
// Revision    : 1.0 - initial release
// ============================================================================
module test_run_ctrl
  import test_pkg::*;
#(
  parameter int          XLEN       = DEF_XLEN,
  parameter int          DEPTH      = 16,
  parameter int          RST_CYCLES = 4,
  parameter int          TIMEOUT    = 100000,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic          clk,
  input  logic          reset,
  test_run_ctrl_if.slave bus
);

  localparam int          CW        = $clog2(DEPTH) + 1;
  localparam int          EW        = XLEN + 5;
  localparam logic [15:0] HOLD_LOAD = 16'(RST_CYCLES);
  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  localparam logic [1:0] S_IDLE = RUN_IDLE;
  localparam logic [1:0] S_HOLD = RUN_HOLD;
  localparam logic [1:0] S_RUN  = RUN_RUN;
  localparam logic [1:0] S_DONE = RUN_DONE;

  logic [1:0]      state_q, state_d;
  logic [15:0]     hold_cnt_q, hold_cnt_d;
  logic [31:0]     cycle_count_q, cycle_count_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            core_reset_q, core_reset_d;
  fail_code_t      fail_code_q, fail_code_d;
  logic [4:0]      fail_addr_q, fail_addr_d;
  logic [XLEN-1:0] fail_data_q, fail_data_d;
  logic [XLEN-1:0] fail_exp_q, fail_exp_d;

  logic            fifo_push, fifo_pop, fifo_flush;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   fifo_head;
  logic [4:0]      head_addr;
  logic [XLEN-1:0] head_data;
  logic            wb_qual, halt_seen, wb_fail;
  logic [CW-1:0]   left_after_pop;

  // Space is judged from the registered count only, so a pop in the same
  // cycle never makes room for a push while the FIFO is full.
  assign bus.exp_ready = (state_q != S_DONE) && !fifo_full;
  assign fifo_push     = bus.exp_valid && bus.exp_ready;

  assign head_addr = fifo_head[EW-1 -: 5];
  assign head_data = fifo_head[XLEN-1:0];

  // x0 writes are architecturally discarded, so they never consume a trace entry
  assign wb_qual   = bus.wb_en && (bus.wb_addr != 5'd0);
  assign halt_seen = bus.ir_load && (bus.ir_data == HALT_INSTR);

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_exp_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data ({bus.exp_addr, bus.exp_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    cycle_count_d  = cycle_count_q;
    done_d         = done_q;
    pass_d         = pass_q;
    core_reset_d   = core_reset_q;
    fail_code_d    = fail_code_q;
    fail_addr_d    = fail_addr_q;
    fail_data_d    = fail_data_q;
    fail_exp_d     = fail_exp_q;
    fifo_pop       = 1'b0;
    fifo_flush     = 1'b0;
    wb_fail        = 1'b0;
    left_after_pop = fifo_count;

    case (state_q)
      S_IDLE: begin
        core_reset_d = 1'b1;
        if (bus.start) begin
          state_d    = S_HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end

      S_HOLD: begin
        // A zero hold length behaves as a single hold cycle.
        core_reset_d = 1'b1;
        if (hold_cnt_q <= 16'd1) begin
          state_d      = S_RUN;
          core_reset_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q - 16'd1;
        end
      end

      S_RUN: begin
        core_reset_d  = 1'b0;
        cycle_count_d = cycle_count_q + 32'd1;

        if (wb_qual) begin
          if (fifo_empty) begin
            wb_fail     = 1'b1;
            fail_code_d = FAIL_EXTRA;
            fail_addr_d = bus.wb_addr;
            fail_data_d = bus.wb_data;
            fail_exp_d  = '0;
          end else if ((head_addr != bus.wb_addr) || (head_data != bus.wb_data)) begin
            wb_fail     = 1'b1;
            fail_code_d = FAIL_MISMATCH;
            fail_addr_d = bus.wb_addr;
            fail_data_d = bus.wb_data;
            fail_exp_d  = head_data;
          end else begin
            fifo_pop = 1'b1;
          end
        end

        // A same-cycle push is not counted: it lands after the halt decision.
        left_after_pop = fifo_count - CW'(fifo_pop);

        // Writeback outcome first, then halt, then timeout.
        if (wb_fail) begin
          state_d      = S_DONE;
          done_d       = 1'b1;
          pass_d       = 1'b0;
          core_reset_d = 1'b1;
        end else if (halt_seen) begin
          state_d      = S_DONE;
          done_d       = 1'b1;
          core_reset_d = 1'b1;
          if (left_after_pop == '0) begin
            pass_d = 1'b1;
          end else begin
            pass_d      = 1'b0;
            fail_code_d = FAIL_MISSING;
          end
        end else if (cycle_count_d == TIMEOUT_W) begin
          state_d      = S_DONE;
          done_d       = 1'b1;
          pass_d       = 1'b0;
          core_reset_d = 1'b1;
          fail_code_d  = FAIL_TIMEOUT;
        end
      end

      S_DONE: begin
        // Core stays frozen and every result holds until a new run.
        core_reset_d = 1'b1;
        if (bus.start) begin
          fifo_flush    = 1'b1;
          state_d       = S_HOLD;
          hold_cnt_d    = HOLD_LOAD;
          cycle_count_d = '0;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          fail_code_d   = FAIL_NONE;
          fail_addr_d   = '0;
          fail_data_d   = '0;
          fail_exp_d    = '0;
        end
      end

      default: begin
        state_d      = S_IDLE;
        core_reset_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      hold_cnt_q    <= '0;
      cycle_count_q <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      core_reset_q  <= 1'b1;
      fail_code_q   <= FAIL_NONE;
      fail_addr_q   <= '0;
      fail_data_q   <= '0;
      fail_exp_q    <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      cycle_count_q <= cycle_count_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      core_reset_q  <= core_reset_d;
      fail_code_q   <= fail_code_d;
      fail_addr_q   <= fail_addr_d;
      fail_data_q   <= fail_data_d;
      fail_exp_q    <= fail_exp_d;
    end
  end

  assign bus.core_reset  = core_reset_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.fail_code   = fail_code_q;
  assign bus.fail_addr   = fail_addr_q;
  assign bus.fail_data   = fail_data_q;
  assign bus.fail_exp    = fail_exp_q;
  assign bus.cycle_count = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_test_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_run_ctrl
// Description : Directed self-checking bench for test_run_ctrl. A small
//               model of the expected trace decides each run's outcome as
//               stimulus is driven and queues it; the queued result is
//               popped and compared when the controller reports done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_run_ctrl;
  import test_pkg::*;

  localparam int          XLEN       = 64;
  localparam int          DEPTH      = 16;
  localparam int          RST_CYCLES = 4;
  localparam int          TIMEOUT    = 50;
  localparam logic [31:0] HALT       = 32'h0000006F;
  localparam logic [31:0] NOP        = 32'h00000013;

  typedef struct {
    logic        pass;
    logic [2:0]  code;
    logic [4:0]  addr;
    logic [63:0] data;
    logic [63:0] expd;
    logic [31:0] cnt;
    bit          cap;
  } res_t;

  logic clk = 1'b0;
  logic reset;

  test_run_ctrl_if #(.XLEN(XLEN)) bus ();

  test_run_ctrl #(
    .XLEN       (XLEN),
    .DEPTH      (DEPTH),
    .RST_CYCLES (RST_CYCLES),
    .TIMEOUT    (TIMEOUT),
    .HALT_INSTR (HALT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_fail    = 0;
  exp_entry_t mq[$];
  res_t       res_q[$];
  bit         m_over    = 1'b0;
  bit         in_run    = 1'b0;
  int         run_ticks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (in_run) run_ticks++;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.exp_valid = 1'b0;
    bus.exp_addr  = '0;
    bus.exp_data  = '0;
    bus.ir_load   = 1'b0;
    bus.ir_data   = NOP;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
  endtask

  task automatic m_end(input logic p, input logic [2:0] c, input logic [4:0] a,
                       input logic [63:0] d, input logic [63:0] e, input bit cap,
                       input logic [31:0] cnt);
    res_t r;
    r.pass = p; r.code = c; r.addr = a; r.data = d; r.expd = e; r.cap = cap; r.cnt = cnt;
    res_q.push_back(r);
    m_over = 1'b1;
    in_run = 1'b0;
  endtask

  task automatic m_wb(input logic [4:0] a, input logic [63:0] d);
    if (m_over || a == 5'd0) return;
    if (mq.size() == 0)
      m_end(1'b0, 3'd2, a, d, 64'd0, 1'b1, run_ticks);
    else if (mq[0].addr != a || mq[0].data != d)
      m_end(1'b0, 3'd1, a, d, mq[0].data, 1'b1, run_ticks);
    else
      void'(mq.pop_front());
  endtask

  task automatic m_halt();
    if (m_over) return;
    if (mq.size() == 0) m_end(1'b1, 3'd0, 5'd0, 64'd0, 64'd0, 1'b0, run_ticks);
    else                m_end(1'b0, 3'd3, 5'd0, 64'd0, 64'd0, 1'b0, run_ticks);
  endtask

  // One clock of stimulus: optional push, optional writeback, optional halt.
  task automatic step(input bit p, input logic [4:0] pa, input logic [63:0] pd,
                      input bit w, input logic [4:0] wa, input logic [63:0] wd,
                      input bit h);
    bit         rdy;
    exp_entry_t e;
    rdy           = !m_over && (mq.size() < DEPTH);
    bus.exp_valid = p;
    bus.exp_addr  = pa;
    bus.exp_data  = pd;
    bus.wb_en     = w;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    bus.ir_load   = w || h;
    bus.ir_data   = h ? HALT : NOP;
    if (p) chk("exp_ready", {63'd0, bus.exp_ready}, {63'd0, rdy});
    tick();
    idle_inputs();
    if (w) m_wb(wa, wd);
    if (h) m_halt();
    if (p && rdy) begin
      e.addr = pa;
      e.data = pd;
      mq.push_back(e);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [63:0] d);
    step(1'b1, a, d, 1'b0, 5'd0, 64'd0, 1'b0);
  endtask

  task automatic wb(input logic [4:0] a, input logic [63:0] d, input bit h);
    step(1'b0, 5'd0, 64'd0, 1'b1, a, d, h);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    if (m_over) mq.delete();
    m_over    = 1'b0;
    run_ticks = 0;
    for (int i = 0; i < RST_CYCLES; i++) begin
      chk("core_reset_hold", {63'd0, bus.core_reset}, 64'd1);
      tick();
    end
    chk("core_reset_run", {63'd0, bus.core_reset}, 64'd0);
    chk("cycle_count_start", {32'd0, bus.cycle_count}, 64'd0);
    in_run = 1'b1;
  endtask

  task automatic wait_done(input int max_wait, input string tag);
    int   w;
    res_t r;
    w = 0;
    while (bus.done !== 1'b1 && w < max_wait) begin
      tick();
      w++;
    end
    chk({tag, "_done"}, {63'd0, bus.done}, 64'd1);
    if (res_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s_scoreboard: observed no queued result required one", tag);
    end else begin
      r = res_q.pop_front();
      chk({tag, "_pass"},        {63'd0, bus.pass},        {63'd0, r.pass});
      chk({tag, "_fail_code"},   {61'd0, bus.fail_code},   {61'd0, r.code});
      chk({tag, "_cycle_count"}, {32'd0, bus.cycle_count}, {32'd0, r.cnt});
      chk({tag, "_core_reset"},  {63'd0, bus.core_reset},  64'd1);
      chk({tag, "_exp_ready"},   {63'd0, bus.exp_ready},   64'd0);
      if (r.cap) begin
        chk({tag, "_fail_addr"}, {59'd0, bus.fail_addr}, {59'd0, r.addr});
        chk({tag, "_fail_data"}, bus.fail_data, r.data);
        chk({tag, "_fail_exp"},  bus.fail_exp,  r.expd);
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_core_reset"},  {63'd0, bus.core_reset},  64'd1);
    chk({tag, "_done"},        {63'd0, bus.done},        64'd0);
    chk({tag, "_pass"},        {63'd0, bus.pass},        64'd0);
    chk({tag, "_fail_code"},   {61'd0, bus.fail_code},   64'd0);
    chk({tag, "_fail_addr"},   {59'd0, bus.fail_addr},   64'd0);
    chk({tag, "_fail_data"},   bus.fail_data,            64'd0);
    chk({tag, "_fail_exp"},    bus.fail_exp,             64'd0);
    chk({tag, "_cycle_count"}, {32'd0, bus.cycle_count}, 64'd0);
    chk({tag, "_exp_ready"},   {63'd0, bus.exp_ready},   64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running at %0t required earlier finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_reset("por");

    // Happy path, trace loaded while idle; an x0 write is ignored
    push(5'd1, 64'hA0);
    push(5'd2, 64'd2);
    push(5'd3, 64'd5);
    do_start();
    wb(5'd1, 64'hA0, 1'b0);
    wb(5'd0, 64'd7,  1'b0);
    wb(5'd2, 64'd2,  1'b0);
    wb(5'd3, 64'd5,  1'b0);
    wb(5'd0, 64'd0,  1'b0);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
    wait_done(0, "happy");

    // Data mismatch
    do_start();
    push(5'd2, 64'd2);
    wb(5'd2, 64'd3, 1'b0);
    wait_done(0, "mismatch");

    // Writeback with nothing expected
    do_start();
    wb(5'd5, 64'd1, 1'b0);
    wait_done(0, "extra");

    // Halt with an entry still outstanding
    do_start();
    push(5'd4, 64'd9);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
    wait_done(0, "missing");

    // Final matching writeback in the halt cycle
    do_start();
    push(5'd6, 64'h66);
    push(5'd7, 64'h77);
    wb(5'd6, 64'h66, 1'b0);
    wb(5'd7, 64'h77, 1'b1);
    wait_done(0, "wb_halt_pass");

    // Mismatching writeback in the halt cycle outranks missing
    do_start();
    push(5'd6, 64'h66);
    wb(5'd6, 64'h65, 1'b1);
    wait_done(0, "wb_halt_mismatch");

    // No halt: timeout after TIMEOUT run cycles, count then frozen
    do_start();
    m_end(1'b0, 3'd4, 5'd0, 64'd0, 64'd0, 1'b0, 32'(TIMEOUT));
    wait_done(TIMEOUT + 10, "timeout");
    tick();
    chk("timeout_count_frozen", {32'd0, bus.cycle_count}, 64'(TIMEOUT));
    chk("timeout_code_held",    {61'd0, bus.fail_code},   64'd4);

    // Fill the FIFO, then push+pop together while full
    do_start();
    for (int i = 0; i < DEPTH; i++) push(5'(i + 1), 64'(i * 3 + 1));
    chk("exp_ready_full", {63'd0, bus.exp_ready}, 64'd0);
    step(1'b1, 5'd20, 64'hDEAD, 1'b1, 5'd1, 64'd1, 1'b0);
    chk("exp_ready_after_pop", {63'd0, bus.exp_ready},
        {63'd0, (!m_over && mq.size() < DEPTH)});
    chk("run_count_before_reset", {32'd0, bus.cycle_count}, 64'(run_ticks));

    // Reset in the middle of a run
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mq.delete();
    m_over = 1'b0;
    in_run = 1'b0;
    chk_reset("midrun_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
